// File: rtl/cpu_defs.sv
// Shared definitions for the pipelined MIPS CPU and its benches:
// memory map constants, the NOP encoding and the IF/ID payload layout.
package cpu_defs;

  localparam logic [31:0] TEXT_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] INST_NOP       = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // Byte offset of addr from base, widened to 33 bits so the subtraction cannot wrap.
  function automatic logic [32:0] offset33(input logic [31:0] addr, input logic [31:0] base);
    return {1'b0, addr} - {1'b0, base};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline stage register with hold (stall) and bubble (flush) controls.
// Flush has priority over stall; a bubble clears both payload and valid.
module if_id_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         valid_nxt;
  logic [W-1:0] data_nxt;

  always_comb begin
    valid_nxt = valid_d;
    data_nxt  = data_d;
    if (flush) begin
      valid_nxt = 1'b0;
      data_nxt  = '0;
    end else if (stall) begin
      valid_nxt = valid_q;
      data_nxt  = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction memory
// addressing with range checking, and the IF/ID pipeline register.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_ADDR,
  parameter int          IMEM_DEPTH = 1024,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_target,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   IF_PC,
  output logic [31:0]   ID_PC,
  output logic [31:0]   ID_inst,
  output logic [31:0]   ID_pc_plus4,
  output logic          ID_valid,
  output logic          fetch_fault,
  output logic [31:0]   fetch_count
);

  localparam logic [32:0] TEXT_LIMIT = 33'(4 * IMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [32:0] pc_off;
  logic        in_range;
  logic [31:0] fetched;
  logic        load_valid;
  if_id_t      if_id_d, if_id_q;

  always_comb begin
    pc_off    = offset33(pc_q, TEXT_BASE);
    in_range  = (pc_q[1:0] == 2'b00) && !pc_off[32] && (pc_off < TEXT_LIMIT);
    imem_addr = pc_off[AW+1:2];
    fetched   = in_range ? imem_rdata : INST_NOP;

    // Redirect beats stall: the wrong-path fetch must be discarded even when frozen.
    if (redirect) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end

    fault_d    = fault_q | !in_range | (redirect & (|redirect_target[1:0]));
    load_valid = !redirect && !stall && in_range;
    count_d    = load_valid ? count_q + 32'd1 : count_q;

    if_id_d.pc   = pc_q;
    if_id_d.inst = fetched;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= TEXT_BASE;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  if_id_reg #(
    .W ($bits(if_id_t))
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (redirect),
    .valid_d (in_range),
    .data_d  (if_id_d),
    .valid_q (ID_valid),
    .data_q  (if_id_q)
  );

  assign IF_PC       = pc_q;
  assign ID_PC       = if_id_q.pc;
  assign ID_inst     = if_id_q.inst;
  assign ID_pc_plus4 = if_id_q.pc + 32'd4;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule
